led_blink_array: RTL and testbench
==================================

# led_blink_array

Parametrised multi-channel LED blinker, successor to the single-LED fixed-interval blinker. A shared prescaler derives a millisecond-class tick from the board clock. Each of CHANNELS LED outputs runs an independent mode (off, steady, blink, burst) with a runtime-programmable half-period. It sits between board-level control logic (or a CPU register bridge) and the Tang Nano LED pins.

## Interface
- CLK_HZ, 27000000, input clock frequency.
- TICK_HZ, 1000, timebase tick rate; DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- CHANNELS, 4, number of LED outputs (1..16).
- PERIOD_W, 16, half-period field width, in ticks.
- DEFAULT_HALF, 500, channel 0 half-period after reset.
- LED_ACTIVE_LOW, 1, when 1, `led` pins are inverted (logical on = 0).
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write accepted when cfg_valid & cfg_ready.
- cfg_ch  input  CH_W  target channel; CH_W = max(1, clog2(CHANNELS)).
- cfg_mode  input  2  0 IDLE, 1 STEADY, 2 BLINK, 3 BURST.
- cfg_half  input  PERIOD_W  half-period in ticks; 0 is treated as 1.
- cfg_burst  input  8  burst pulse count; 0 is treated as 1.
- led  output  CHANNELS  LED pins, registered.
- burst_done  output  CHANNELS  one-cycle pulse when a burst completes.

## Operation
- Prescaler counts 0..DIV-1. `tick` is high for one cycle when count == DIV-1, then wraps to 0.
- Each channel holds: mode, half, count, burst_left, and a logical state `on`.
- **IDLE:** on = 0; count frozen.
- **STEADY:** on = 1; count frozen.
- **BLINK:** on each tick, count increments. When count == half-1 on a tick, count returns to 0 and `on` toggles.
- **BURST:** same as BLINK. On every on→off toggle, burst_left decrements. The toggle that takes burst_left 1→0 moves the channel to IDLE and pulses burst_done.
- **Accepted write:**
  - Loads mode, half, and burst_left for cfg_ch; count is set to 0.
  - `on` becomes 1 for STEADY, BLINK, and BURST, and 0 for IDLE.
  - Other channels are unaffected.
  - A write to a channel ≥ CHANNELS is accepted and ignored.
- **cfg_ready** = !tick. Writes are never accepted on a tick cycle, so a tick update and a write never collide. A held request is accepted on the next cycle.
- **Output mapping:** led[i] = on[i] ^ LED_ACTIVE_LOW.

## Timing
- **Reset values:**
  - All `on` = 0, so led = {CHANNELS{LED_ACTIVE_LOW}}.
  - burst_done = 0; prescaler = 0; all counts = 0.
  - Channel 0 mode = BLINK with half = DEFAULT_HALF; other channels IDLE with half = 1.
  - cfg_ready is 1 while in reset. Writes during reset are ignored.
- **First tick:** occurs on cycle DIV-1 after reset release (cycle 0 is the first edge with rst low).
- **Write latency:** led reflects a write 1 cycle after acceptance.
- **Blink timing:** a BLINK channel with half H toggles led every H·DIV cycles. The first toggle after a write occurs H·DIV cycles after acceptance, aligned to the tick grid, so the first phase may be shorter by up to DIV-1 cycles.
- **burst_done:** asserted in the same cycle led shows the final off state. Lasts exactly one cycle.
- **Reset mid-operation:** asynchronous reset forces all outputs to their reset values immediately, without waiting for a clk edge.

## Configuration
- **LED_BLINK_BURST_EN defined:** BURST mode, burst_left counters, and burst_done logic are compiled in.
- **Not defined:**
  - cfg_mode 3 behaves exactly as BLINK.
  - burst_done is tied to 0.
  - cfg_burst is ignored and no burst registers exist.

## Structure
- **Package `led_blink_pkg`:**
  - Mode constants: MODE_IDLE, MODE_STEADY, MODE_BLINK, MODE_BURST.
  - 2-bit mode type.
  - Burst-count width constant (8).
- **Sub-module `led_blink_chan`:**
  - One instance per channel, generated CHANNELS times.
  - Ports: clk, rst, tick, wr_en, mode, half, burst, on, burst_done.
  - Reset-default mode and half are set by parameters.
- **Top level:** holds the prescaler, cfg_ready, channel decode, and output inversion.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), CHANNELS=4, DEFAULT_HALF=3, LED_ACTIVE_LOW=1.

- **Reset default:** release reset, no writes → led = 4'b1111 at release. led[0] toggles every 30 cycles: first low at cycle 29 + 1 register cycle, i.e. visible on the edge after the third tick. led[3:1] stay 1.
- **STEADY:** write ch1 STEADY → led[1] = 0 one cycle after acceptance, held indefinitely across ticks.
- **BURST (macro defined):** write ch2 BURST, half=2, burst=3 → led[2] shows 3 low pulses, each 20 cycles on / 20 off. burst_done[2] pulses once, coincident with the final return of led[2] to 1. Channel then stays IDLE.
- **Write on tick:** assert cfg_valid on a tick cycle → cfg_ready = 0 that cycle. Write accepted the next cycle; no tick lost on any channel.
- **Zero fields:** write ch3 BLINK, half=0 → led[3] toggles every 10 cycles. Write ch3 BURST, burst=0 → exactly one pulse, then burst_done[3].
- **Async reset:** assert rst mid-burst between clock edges → led = 4'b1111 and burst_done = 0 before the next clk edge. After release, the default sequence restarts.

Source files
------------

// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared types and widths for the multi-channel LED blinker.
package led_blink_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned BURST_W = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BURST  = 2'd3
  } mode_t;

endpackage

// File: rtl/led_blink_chan.sv
// led_blink_chan: one LED channel (mode, half-period counter, optional burst counter).
// Optional feature macro: LED_BLINK_BURST_EN (burst counting and burst_done pulse).
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter mode_t       RST_MODE = MODE_IDLE,
  parameter int unsigned RST_HALF = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                wr_en,
  input  mode_t               mode,
  input  logic [PERIOD_W-1:0] half,
  input  logic [BURST_W-1:0]  burst,
  output logic                on,
  output logic                burst_done
);

  mode_t               mode_q, mode_nxt;
  logic [PERIOD_W-1:0] half_q, half_nxt;
  logic [PERIOD_W-1:0] count_q, count_nxt;
  logic                on_nxt;
  logic                at_wrap;

`ifdef LED_BLINK_BURST_EN
  logic [BURST_W-1:0]  left_q, left_nxt;
  logic                done_nxt;
`else
  logic                unused_burst;
  assign unused_burst = ^burst;
  assign burst_done   = 1'b0;
`endif

  // Half-period boundary: half is never stored as zero, so half-1 cannot underflow.
  assign at_wrap = (count_q == (half_q - PERIOD_W'(1)));

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= RST_MODE;
      half_q     <= PERIOD_W'(RST_HALF);
      count_q    <= '0;
      on         <= 1'b0;
`ifdef LED_BLINK_BURST_EN
      left_q     <= '0;
      burst_done <= 1'b0;
`endif
    end else begin
      mode_q     <= mode_nxt;
      half_q     <= half_nxt;
      count_q    <= count_nxt;
      on         <= on_nxt;
`ifdef LED_BLINK_BURST_EN
      left_q     <= left_nxt;
      burst_done <= done_nxt;
`endif
    end
  end

  // Next-state: a write reloads the channel; otherwise blink modes advance on tick.
  always_comb begin
    mode_nxt  = mode_q;
    half_nxt  = half_q;
    count_nxt = count_q;
    on_nxt    = on;
`ifdef LED_BLINK_BURST_EN
    left_nxt  = left_q;
    done_nxt  = 1'b0;
`endif
    if (wr_en) begin
`ifdef LED_BLINK_BURST_EN
      mode_nxt = mode;
      left_nxt = (burst == '0) ? BURST_W'(1) : burst;
`else
      mode_nxt = (mode == MODE_BURST) ? MODE_BLINK : mode;
`endif
      half_nxt  = (half == '0) ? PERIOD_W'(1) : half;
      count_nxt = '0;
      on_nxt    = (mode != MODE_IDLE);
    end else if (tick && ((mode_q == MODE_BLINK) || (mode_q == MODE_BURST))) begin
      if (at_wrap) begin
        count_nxt = '0;
        on_nxt    = !on;
`ifdef LED_BLINK_BURST_EN
        // Each on->off edge consumes one burst pulse; the last one parks the channel.
        if ((mode_q == MODE_BURST) && on) begin
          if (left_q == BURST_W'(1)) begin
            left_nxt = '0;
            mode_nxt = MODE_IDLE;
            done_nxt = 1'b1;
          end else begin
            left_nxt = left_q - BURST_W'(1);
          end
        end
`endif
      end else begin
        count_nxt = count_q + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_blink_array.sv
// led_blink_array: shared tick prescaler, config write port and CHANNELS LED channels.
// Optional feature macro: LED_BLINK_BURST_EN (BURST mode and burst_done outputs).
module led_blink_array
  import led_blink_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 27000000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned PERIOD_W       = 16,
  parameter int unsigned DEFAULT_HALF   = 500,
  parameter bit          LED_ACTIVE_LOW = 1'b1,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half,
  input  logic [BURST_W-1:0]  cfg_burst,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] burst_done
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] on_vec;

  // Prescaler; tick and cfg_ready are registered so tick is high exactly when pre_cnt == DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      pre_cnt   <= tick ? '0 : (pre_cnt + PRE_W'(1));
      tick      <= (pre_cnt == PRE_W'(DIV - 2));
      cfg_ready <= (pre_cnt != PRE_W'(DIV - 2));
    end
  end

  // One channel per LED; channel 0 comes out of reset blinking.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam mode_t       RM = (i == 0) ? MODE_BLINK : MODE_IDLE;
    localparam int unsigned RH = (i == 0) ? DEFAULT_HALF : 1;

    assign wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    led_blink_chan #(
      .PERIOD_W (PERIOD_W),
      .RST_MODE (RM),
      .RST_HALF (RH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .wr_en      (wr_en[i]),
      .mode       (mode_t'(cfg_mode)),
      .half       (cfg_half),
      .burst      (cfg_burst),
      .on         (on_vec[i]),
      .burst_done (burst_done[i])
    );
  end

  // Pin polarity.
  assign led = on_vec ^ {CHANNELS{LED_ACTIVE_LOW}};

endmodule

// File: tb/tb_led_blink_array.sv
// tb_led_blink_array: directed bench, DIV=10, 4 channels, DEFAULT_HALF=3, active-low LEDs.
// Expectations follow the LED_BLINK_BURST_EN setting of the build.
module tb_led_blink_array;
  import led_blink_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_half = '0;
  logic [7:0]  cfg_burst = '0;
  logic [3:0]  led;
  logic [3:0]  burst_done;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = -1;

  led_blink_array #(
    .CLK_HZ         (100),
    .TICK_HZ        (10),
    .CHANNELS       (4),
    .PERIOD_W       (16),
    .DEFAULT_HALF   (3),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_half   (cfg_half),
    .cfg_burst  (cfg_burst),
    .led        (led),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  // Edge index since reset release: edge 0 is the first rising edge with rst low.
  always @(posedge clk) edge_n <= rst ? -1 : edge_n + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic goto_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] m,
                           input logic [15:0] h, input logic [7:0] b);
    int n = 0;
    cfg_ch = ch; cfg_mode = m; cfg_half = h; cfg_burst = b; cfg_valid = 1'b1;
    while (!cfg_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) begin
      vectors++;
      miscompares++;
      $display("FAIL cfg_write_timeout: cfg_ready got 0 for 20 cycles, want 1");
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    int         e_tab [9] = '{0, 8, 9, 28, 29, 58, 59, 88, 89};
    logic [3:0] l_tab [9] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hE};
    logic       r_tab [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = MODE_STEADY; cfg_half = 16'd1; cfg_burst = 8'd1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (led !== 4'hF) begin
      miscompares++; $display("FAIL reset_led: got %b want 1111", led);
    end
    vectors++;
    if (burst_done !== 4'h0) begin
      miscompares++; $display("FAIL reset_done: got %b want 0000", burst_done);
    end
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", cfg_ready);
    end
    cfg_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      goto_edge(e_tab[i]);
      vectors++;
      if (led !== l_tab[i]) begin
        miscompares++; $display("FAIL default_led edge %0d: got %b want %b", e_tab[i], led, l_tab[i]);
      end
      vectors++;
      if (cfg_ready !== r_tab[i]) begin
        miscompares++; $display("FAIL default_ready edge %0d: got %b want %b", e_tab[i], cfg_ready, r_tab[i]);
      end
    end
  endtask

  task automatic test_steady;
    cfg_write(2'd1, MODE_STEADY, 16'd7, 8'd0);
    vectors++;
    if (led !== 4'b1100) begin
      miscompares++; $display("FAIL steady_accept edge %0d: got %b want 1100", edge_n, led);
    end
    goto_edge(130);
    vectors++;
    if (led !== 4'b1101) begin
      miscompares++; $display("FAIL steady_hold edge 130: got %b want 1101", led);
    end
  endtask

  task automatic test_write_on_tick;
    int         e_tab [4] = '{148, 149, 159, 169};
    logic [3:0] l_tab [4] = '{4'b0101, 4'b1100, 4'b0100, 4'b1100};
    goto_edge(138);
    vectors++;
    if (cfg_ready !== 1'b0) begin
      miscompares++; $display("FAIL tick_ready edge 138: got %b want 0", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_mode = MODE_BLINK; cfg_half = 16'd0; cfg_burst = 8'd0;
    @(posedge clk);
    #1;
    vectors++;
    if (cfg_ready !== 1'b1 || led !== 4'b1101) begin
      miscompares++; $display("FAIL tick_held edge 139: got ready %b led %b want 1 1101", cfg_ready, led);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    vectors++;
    if (led !== 4'b0101) begin
      miscompares++; $display("FAIL tick_accept edge 140: got %b want 0101", led);
    end
    for (int i = 0; i < 4; i++) begin
      goto_edge(e_tab[i]);
      vectors++;
      if (led !== l_tab[i]) begin
        miscompares++; $display("FAIL tick_blink edge %0d: got %b want %b", e_tab[i], led, l_tab[i]);
      end
    end
  endtask

  task automatic test_burst;
    int         e_tab [14] = '{170, 188, 189, 208, 209, 228, 229, 248, 249, 268, 269, 270, 289, 300};
`ifdef LED_BLINK_BURST_EN
    logic       l_tab [14] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    logic [3:0] d_tab [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0, 0, 0};
`else
    logic       l_tab [14] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    logic [3:0] d_tab [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    cfg_write(2'd2, MODE_BURST, 16'd2, 8'd3);
    for (int i = 0; i < 14; i++) begin
      goto_edge(e_tab[i]);
      vectors++;
      if (led[2] !== l_tab[i] || burst_done !== d_tab[i]) begin
        miscompares++;
        $display("FAIL burst edge %0d: got led2 %b done %b want %b %b", e_tab[i], led[2], burst_done, l_tab[i], d_tab[i]);
      end
    end
  endtask

  task automatic test_zero_fields;
    int         e_tab [6] = '{301, 308, 309, 310, 319, 329};
`ifdef LED_BLINK_BURST_EN
    logic       l_tab [6] = '{0, 0, 1, 1, 1, 1};
    logic [3:0] d_tab [6] = '{0, 0, 4'b1000, 0, 0, 0};
`else
    logic       l_tab [6] = '{0, 0, 1, 1, 0, 1};
    logic [3:0] d_tab [6] = '{0, 0, 0, 0, 0, 0};
`endif
    cfg_write(2'd3, MODE_BURST, 16'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      goto_edge(e_tab[i]);
      vectors++;
      if (led[3] !== l_tab[i] || burst_done !== d_tab[i]) begin
        miscompares++;
        $display("FAIL zero_fields edge %0d: got led3 %b done %b want %b %b", e_tab[i], led[3], burst_done, l_tab[i], d_tab[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    int         e_tab [4] = '{0, 8, 28, 29};
    logic [3:0] l_tab [4] = '{4'hF, 4'hF, 4'hF, 4'hE};
    logic       r_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] d_exp;
`ifdef LED_BLINK_BURST_EN
    d_exp = 4'b0100;
`else
    d_exp = 4'b0000;
`endif
    cfg_write(2'd2, MODE_BURST, 16'd1, 8'd1);
    vectors++;
    if (led[2] !== 1'b0) begin
      miscompares++; $display("FAIL async_setup edge %0d: got led2 %b want 0", edge_n, led[2]);
    end
    goto_edge(339);
    vectors++;
    if (led[2] !== 1'b1 || burst_done !== d_exp) begin
      miscompares++; $display("FAIL async_pulse edge 339: got led2 %b done %b want 1 %b", led[2], burst_done, d_exp);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (led !== 4'hF || burst_done !== 4'h0) begin
      miscompares++; $display("FAIL async_assert: got led %b done %b want 1111 0000", led, burst_done);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      goto_edge(e_tab[i]);
      vectors++;
      if (led !== l_tab[i] || cfg_ready !== r_tab[i]) begin
        miscompares++;
        $display("FAIL restart edge %0d: got led %b ready %b want %b %b", e_tab[i], led, cfg_ready, l_tab[i], r_tab[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_steady;
    test_write_on_tick;
    test_burst;
    test_zero_fields;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
